// File: rtl/song_bram_loader.sv
// Streams signed 8-bit PCM from consecutive SD blocks into the song BRAM,
// one byte per address, and reports the loaded length when finished.
module song_bram_loader #(
   parameter int unsigned ADDR_W      = 18,
   parameter int unsigned MAX_SAMPLES = 192000,
   parameter int unsigned BLOCK_BYTES = 512,
   parameter int unsigned START_BLOCK = 0,
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              sd_init_done_i,
   input  logic              sd_init_error_i,
   output logic              blk_req_o,
   output logic [31:0]       blk_addr_o,
   input  logic              byte_valid_i,
   input  logic [7:0]        rd_byte_i,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [7:0]        ram_din_o,
   output logic              load_busy_o,
   output logic              load_done_o,
   output logic              load_error_o,
   output logic [ADDR_W-1:0] song_length_o
);

   localparam int unsigned ByteW = $clog2(BLOCK_BYTES + 1);
   localparam int unsigned ToW   = $clog2(TIMEOUT_CYC + 1);

   localparam logic [ADDR_W-1:0] MaxSamples = ADDR_W'(MAX_SAMPLES);
   localparam logic [ByteW-1:0]  LastByte   = ByteW'(BLOCK_BYTES - 1);
   localparam logic [ToW-1:0]    ToLast     = ToW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      StIdle, StWaitInit, StReq, StRecv, StNext, StDone, StError
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   sample_cnt_q, sample_cnt_d;
   logic [31:0]         blk_cnt_q, blk_cnt_d;
   logic [ByteW-1:0]    byte_cnt_q, byte_cnt_d;
   logic [ToW-1:0]      to_cnt_q, to_cnt_d;
   logic [ADDR_W-1:0]   song_len_q, song_len_d;
   logic                ram_we_q, ram_we_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [7:0]          ram_din_q, ram_din_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         sample_cnt_q <= '0;
         blk_cnt_q    <= '0;
         byte_cnt_q   <= '0;
         to_cnt_q     <= '0;
         song_len_q   <= '0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_din_q    <= '0;
      end else begin
         state_q      <= state_d;
         sample_cnt_q <= sample_cnt_d;
         blk_cnt_q    <= blk_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         to_cnt_q     <= to_cnt_d;
         song_len_q   <= song_len_d;
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_din_q    <= ram_din_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      sample_cnt_d = sample_cnt_q;
      blk_cnt_d    = blk_cnt_q;
      byte_cnt_d   = byte_cnt_q;
      to_cnt_d     = to_cnt_q;
      song_len_d   = song_len_q;
      ram_we_d     = 1'b0;
      ram_addr_d   = ram_addr_q;
      ram_din_d    = ram_din_q;
      unique case (state_q)
         StIdle, StDone, StError: begin
            // Every (re)load starts over from the first block.
            if (start_i) begin
               state_d      = StWaitInit;
               sample_cnt_d = '0;
               blk_cnt_d    = '0;
               byte_cnt_d   = '0;
            end
         end
         StWaitInit: begin
            if (sd_init_error_i) begin
               state_d = StError;
            end else if (sd_init_done_i) begin
               state_d = StReq;
            end
         end
         StReq: begin
            byte_cnt_d = '0;
            to_cnt_d   = '0;
            state_d    = StRecv;
         end
         StRecv: begin
            if (sd_init_error_i) begin
               state_d = StError;
            end else if (byte_valid_i) begin
               byte_cnt_d = byte_cnt_q + 1'b1;
               to_cnt_d   = '0;
               // Bytes past the song length are consumed but not stored.
               if (sample_cnt_q < MaxSamples) begin
                  ram_we_d     = 1'b1;
                  ram_addr_d   = sample_cnt_q;
                  ram_din_d    = rd_byte_i;
                  sample_cnt_d = sample_cnt_q + 1'b1;
               end
               if (byte_cnt_q == LastByte) begin
                  state_d = StNext;
               end
            end else if (to_cnt_q == ToLast) begin
               state_d = StError;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         StNext: begin
            if (sample_cnt_q == MaxSamples) begin
               state_d    = StDone;
               song_len_d = sample_cnt_q;
            end else begin
               blk_cnt_d = blk_cnt_q + 32'd1;
               state_d   = StReq;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign blk_req_o     = (state_q == StReq);
   assign blk_addr_o    = blk_req_o ? (32'(START_BLOCK) + blk_cnt_q) : 32'd0;
   assign ram_we_o      = ram_we_q;
   assign ram_addr_o    = ram_addr_q;
   assign ram_din_o     = ram_din_q;
   assign load_busy_o   = !(state_q inside {StIdle, StDone, StError});
   assign load_done_o   = (state_q == StDone);
   assign load_error_o  = (state_q == StError);
   assign song_length_o = song_len_q;

endmodule

// File: tb/tb_song_bram_loader.sv
// Bench for song_bram_loader: a byte-index model predicts every BRAM write,
// and directed scenarios pin lengths, block addresses and timeout latency.
module tb_song_bram_loader;

   localparam int AW   = 18;
   localparam int MAXS = 1000;
   localparam int BB   = 512;
   localparam int TO   = 50;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          init_done = 1'b0;
   logic          init_err = 1'b0;
   logic          bv = 1'b0;
   logic [7:0]    rb = 8'd0;
   logic          blk_req;
   logic [31:0]   blk_addr;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_din;
   logic          load_busy;
   logic          load_done;
   logic          load_error;
   logic [AW-1:0] song_length;

   song_bram_loader #(
      .ADDR_W      (AW),
      .MAX_SAMPLES (MAXS),
      .BLOCK_BYTES (BB),
      .START_BLOCK (0),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .start_i         (start),
      .sd_init_done_i  (init_done),
      .sd_init_error_i (init_err),
      .blk_req_o       (blk_req),
      .blk_addr_o      (blk_addr),
      .byte_valid_i    (bv),
      .rd_byte_i       (rb),
      .ram_we_o        (ram_we),
      .ram_addr_o      (ram_addr),
      .ram_din_o       (ram_din),
      .load_busy_o     (load_busy),
      .load_done_o     (load_done),
      .load_error_o    (load_error),
      .song_length_o   (song_length)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: byte k of the current load (as delivered by the reader) lands at
   // address k with data rd_byte one cycle later, provided k < MAXS.
   bit            accept = 1'b0;
   int            sidx = 0;
   logic          exp_we = 1'b0;
   logic [AW-1:0] exp_addr = '0;
   logic [7:0]    exp_din = '0;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         exp_we = 1'b0;
      end else begin
         exp_we = bv && accept && (sidx < MAXS);
         if (exp_we) begin
            exp_addr = AW'(sidx);
            exp_din  = rb;
         end
      end
   end

   bit          chk_en = 1'b0;
   int          n_wr = 0;
   int          n_req = 0;
   logic [31:0] req_addr[$];

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("ram_we", 64'(ram_we), 64'(exp_we));
         if (exp_we) begin
            chk("ram_addr", 64'(ram_addr), 64'(exp_addr));
            chk("ram_din", 64'(ram_din), 64'(exp_din));
         end
         if (ram_we) n_wr++;
         if (blk_req) begin
            n_req++;
            req_addr.push_back(blk_addr);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_req(input int exp_blk);
      bit ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (blk_req) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("blk_req_seen", 64'(ok), 64'd1);
      if (ok) chk("blk_addr", 64'(blk_addr), 64'(exp_blk));
   endtask

   // Serve one block; optionally pulse start together with byte start_at.
   task automatic serve_block(input int blk, input int nbytes, input int gap, input int start_at);
      wait_req(blk);
      tick();
      for (int i = 0; i < nbytes; i++) begin
         sidx   = blk * BB + i;
         rb     = 8'(sidx % 256);
         bv     = 1'b1;
         accept = 1'b1;
         start  = (i == start_at);
         tick();
         bv    = 1'b0;
         start = 1'b0;
         for (int g = 0; g < gap; g++) tick();
      end
      accept = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ram_we"}, 64'(ram_we), 64'd0);
      chk({tag, "_ram_addr"}, 64'(ram_addr), 64'd0);
      chk({tag, "_ram_din"}, 64'(ram_din), 64'd0);
      chk({tag, "_blk_req"}, 64'(blk_req), 64'd0);
      chk({tag, "_blk_addr"}, 64'(blk_addr), 64'd0);
      chk({tag, "_busy"}, 64'(load_busy), 64'd0);
      chk({tag, "_done"}, 64'(load_done), 64'd0);
      chk({tag, "_error"}, 64'(load_error), 64'd0);
      chk({tag, "_song_length"}, 64'(song_length), 64'd0);
   endtask

   int wr0, rq0, cnt;

   initial begin
      // Reset values.
      tick();
      tick();
      chk_all_zero("reset");
      rst_n = 1'b1;
      chk_en = 1'b1;
      init_done = 1'b1;
      tick();
      chk("idle_busy", 64'(load_busy), 64'd0);

      // Full load of 1000 samples from two blocks.
      wr0 = n_wr;
      rq0 = n_req;
      pulse_start();
      chk("load_busy_after_start", 64'(load_busy), 64'd1);
      serve_block(0, BB, 0, -1);
      serve_block(1, BB, 0, -1);
      for (int i = 0; i < 4; i++) tick();
      chk("full_done", 64'(load_done), 64'd1);
      chk("full_busy", 64'(load_busy), 64'd0);
      chk("full_song_length", 64'(song_length), 64'd1000);
      chk("full_writes", 64'(n_wr - wr0), 64'd1000);
      chk("full_reqs", 64'(n_req - rq0), 64'd2);
      if (n_req - rq0 == 2) begin
         chk("full_req0_addr", 64'(req_addr[rq0]), 64'd0);
         chk("full_req1_addr", 64'(req_addr[rq0 + 1]), 64'd1);
      end

      // Card init failure while waiting.
      wr0 = n_wr;
      rq0 = n_req;
      init_done = 1'b0;
      pulse_start();
      chk("winit_done_cleared", 64'(load_done), 64'd0);
      chk("winit_busy", 64'(load_busy), 64'd1);
      tick();
      tick();
      chk("winit_holds", 64'(load_busy), 64'd1);
      init_err = 1'b1;
      tick();
      chk("init_err_error", 64'(load_error), 64'd1);
      chk("init_err_busy", 64'(load_busy), 64'd0);
      init_err = 1'b0;
      tick();
      chk("init_err_no_req", 64'(n_req - rq0), 64'd0);
      chk("init_err_no_we", 64'(n_wr - wr0), 64'd0);
      chk("init_err_song_length", 64'(song_length), 64'd1000);

      // Reader stalls after 100 bytes: error exactly TO cycles after last byte.
      init_done = 1'b1;
      pulse_start();
      chk("retry_error_cleared", 64'(load_error), 64'd0);
      serve_block(0, 100, 0, -1);
      cnt = 0;
      while (!load_error && cnt < 200) begin
         tick();
         cnt++;
      end
      chk("timeout_cycles", 64'(cnt), 64'd50);
      chk("timeout_song_length", 64'(song_length), 64'd1000);
      pulse_start();
      wait_req(0);
      chk("retry_song_length", 64'(song_length), 64'd1000);

      // Asynchronous reset mid-RECV while a write is in flight.
      tick();
      for (int i = 0; i < 3; i++) begin
         sidx   = i;
         rb     = 8'(i + 7);
         bv     = 1'b1;
         accept = 1'b1;
         tick();
      end
      bv = 1'b0;
      accept = 1'b0;
      chk("pre_reset_we", 64'(ram_we), 64'd1);
      chk("pre_reset_din", 64'(ram_din), 64'd9);
      chk_en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      tick();
      tick();
      rst_n = 1'b1;
      chk_en = 1'b1;
      wr0 = n_wr;
      for (int i = 0; i < 4; i++) begin
         bv = 1'b1;
         rb = 8'hA5;
         tick();
      end
      bv = 1'b0;
      tick();
      tick();
      chk("post_reset_no_we", 64'(n_wr - wr0), 64'd0);
      chk("post_reset_idle", 64'(load_busy), 64'd0);

      // start pulsed during RECV is ignored; strobes in DONE are ignored.
      rq0 = n_req;
      pulse_start();
      serve_block(0, BB, 0, 200);
      serve_block(1, BB, 0, -1);
      for (int i = 0; i < 4; i++) tick();
      chk("ign_reqs", 64'(n_req - rq0), 64'd2);
      chk("ign_done", 64'(load_done), 64'd1);
      chk("ign_song_length", 64'(song_length), 64'd1000);
      wr0 = n_wr;
      for (int i = 0; i < 3; i++) begin
         bv = 1'b1;
         rb = 8'h5A;
         tick();
      end
      bv = 1'b0;
      tick();
      tick();
      chk("done_strobe_no_we", 64'(n_wr - wr0), 64'd0);
      chk("done_strobe_done", 64'(load_done), 64'd1);

      // Alternate-cycle strobes.
      wr0 = n_wr;
      pulse_start();
      chk("alt_done_cleared", 64'(load_done), 64'd0);
      chk("alt_busy", 64'(load_busy), 64'd1);
      serve_block(0, BB, 1, -1);
      serve_block(1, BB, 1, -1);
      for (int i = 0; i < 4; i++) tick();
      chk("alt_writes", 64'(n_wr - wr0), 64'd1000);
      chk("alt_done", 64'(load_done), 64'd1);
      chk("alt_song_length", 64'(song_length), 64'd1000);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
